// File: rtl/dmux4way_sched.sv
// dmux4way_sched: 1-to-4 demultiplexer with a single holding register.
// Words are routed by round-robin over enabled outputs or to a fixed output.
// Routing controls are sampled only when a word is accepted.
// A new word can be accepted in the same cycle the held word is delivered.
module dmux4way_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [1:0]       fixed_sel,
    input  logic [3:0]       en_mask,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       sel,
    output logic [7:0]       xfer_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t     state;
    logic [1:0] last_dest;
    logic [1:0] target;
    logic       target_valid;
    logic [1:0] idx;
    logic       in_hs;
    logic       out_hs;

    // Destination for the next accepted word.
    // Round-robin scans upward from last_dest + 1 and wraps; the last candidate is last_dest itself.
    always_comb begin
        target       = fixed_sel;
        target_valid = en_mask[fixed_sel];
        idx          = 2'd0;
        if (!mode) begin
            target       = last_dest + 2'd1;
            target_valid = 1'b0;
            // Scan from the farthest candidate down, so the nearest enabled one is written last.
            for (int k = 3; k >= 0; k--) begin
                idx = last_dest + 2'(k) + 2'd1;
                if (en_mask[idx]) begin
                    target       = idx;
                    target_valid = 1'b1;
                end
            end
        end
    end

    // Handshake qualification. Only the ready of the held word's destination is looked at.
    always_comb begin
        out_hs   = (state == SEND) && out_ready[sel];
        in_ready = target_valid && ((state == IDLE) || out_ready[sel]);
        in_hs    = in_valid && in_ready;
    end

    // FSM with registered outputs. An output handshake and a new accept can happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_data  <= '0;
            sel       <= 2'd0;
            last_dest <= 2'd3;
            out_valid <= 4'b0000;
            xfer_cnt  <= 8'd0;
        end else begin
            if (in_hs) begin
                state     <= SEND;
                out_data  <= in_data;
                sel       <= target;
                last_dest <= target;
                out_valid <= 4'b0001 << target;
            end else if (out_hs) begin
                state     <= IDLE;
                out_valid <= 4'b0000;
            end
            if (out_hs) begin
                xfer_cnt <= xfer_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/dmux4way_sched.md
DMUX4WAY_SCHED -- requirements
Module: dmux4way_sched

Interface
REQ-001 Parameter WIDTH, default 8, sets the data word width in bits.
REQ-002 Port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port in_data, input, WIDTH, the word offered by the upstream source.
REQ-005 Port in_valid, input, 1, upstream word valid.
REQ-006 Port in_ready, output, 1, block accepts the word this cycle.
REQ-007 Port mode, input, 1, routing mode: 0 = round-robin, 1 = fixed.
REQ-008 Port fixed_sel, input, 2, destination index used in fixed mode.
REQ-009 Port en_mask, input, 4, per-destination enable; bit i enables output i.
REQ-010 Port out_data, output, WIDTH, held word, shared by all four outputs.
REQ-011 Port out_valid, output, 4, one-hot-or-zero valid toward outputs 0..3.
REQ-012 Port out_ready, input, 4, per-destination ready from outputs 0..3.
REQ-013 Port sel, output, 2, destination index of the held word (the demux select).
REQ-014 Port xfer_cnt, output, 8, count of completed output handshakes.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE (no word held) and SEND (one word held for destination sel).
REQ-016 The block SHALL define "target" combinationally.
- Fixed mode: target = fixed_sel, valid only if en_mask[fixed_sel] = 1.
- Round-robin mode: target = the first enabled index after last_dest, scanning upward with wrap 3->0; valid only if en_mask != 0.
REQ-017 The block SHALL drive in_ready = target_valid AND (state = IDLE OR (state = SEND AND out_ready[sel])).
REQ-018 An input handshake (in_valid AND in_ready) SHALL register in_data into out_data, target into sel and last_dest, and enter or stay in SEND.
REQ-019 In SEND, out_valid[sel] SHALL be 1 and all other out_valid bits 0; in IDLE, out_valid SHALL be 0.
REQ-020 An output handshake (out_ready[sel] in SEND) SHALL return the FSM to IDLE unless an input handshake occurs in the same cycle, in which case the FSM stays in SEND with the new word (throughput of one word per cycle).
REQ-021 out_data and sel SHALL stay stable while out_valid is asserted and out_ready[sel] = 0.
REQ-022 mode, fixed_sel and en_mask SHALL be sampled only at input handshake; changing them while in SEND SHALL NOT redirect or drop the held word.
REQ-023 Deasserting en_mask[sel] while in SEND SHALL still deliver the held word to sel.
REQ-024 out_ready bits for destinations other than sel SHALL be ignored.
REQ-025 xfer_cnt SHALL increment by 1 on each output handshake and wrap 255 -> 0.
REQ-026 With en_mask = 0, or in fixed mode with en_mask[fixed_sel] = 0, in_ready SHALL be 0 and no word is accepted.
REQ-027 Output latency SHALL be one cycle: a word accepted at edge N is offered on out_valid from edge N onward.

Reset
REQ-028 While rst_n = 0, the block SHALL immediately force the following, independent of clk:
- FSM = IDLE
- out_valid = 0, out_data = 0, sel = 0
- last_dest = 3, so that the first round-robin target is output 0
- xfer_cnt = 0
REQ-029 A reset asserted while in SEND SHALL discard the held word without any output handshake.
REQ-030 After rst_n rises, the first input handshake SHALL be accepted no earlier than the first rising clk edge.

Verification
REQ-031 Round-robin wrap: mode = 0, en_mask = 1111, all out_ready = 1, four back-to-back words A, B, C, D, then E -> delivered to outputs 0, 1, 2, 3, 0 on consecutive cycles; xfer_cnt = 5.
REQ-032 Skip disabled outputs: mode = 0, en_mask = 1010, three words -> delivered to outputs 1, 3, 1.
REQ-033 Backpressure: mode = 1, fixed_sel = 2, out_ready[2] = 0 for 3 cycles, then 1 -> out_valid = 0100 held with stable out_data; in_ready = 0 during the stall; delivery occurs on the 4th cycle.
REQ-034 Fixed mode, destination disabled: mode = 1, fixed_sel = 3, en_mask = 0111, in_valid = 1 -> in_ready = 0 and out_valid = 0000 indefinitely.
REQ-035 Mid-operation changes: en_mask cleared and mode toggled while in SEND -> the held word is still delivered to the original sel.
REQ-036 Reset mid-operation and counter wrap:
- rst_n pulsed low in SEND -> out_valid = 0 immediately, and the next round-robin word goes to output 0.
- 256 transfers -> xfer_cnt = 0.
